// File: rtl/wrr_arbiter_if.sv
// wrr_arbiter_if: request/grant/end_transaction bundle between the agents and the arbiter
interface wrr_arbiter_if #(
    parameter int N_AGENTS = 4,
    parameter int WEIGHT_W = 3
);
    localparam int IDW = $clog2(N_AGENTS);
    logic [N_AGENTS-1:0]          request;
    logic [N_AGENTS-1:0]          end_transaction;
    logic [N_AGENTS*WEIGHT_W-1:0] weight_cfg;
    logic                         cfg_load;
    logic [N_AGENTS-1:0]          grant;
    logic [IDW-1:0]               grant_id;
    logic                         busy;
    logic                         timeout_pulse;
    logic [IDW-1:0]               timeout_id;
    modport master (
        output request, end_transaction, weight_cfg, cfg_load,
        input  grant, grant_id, busy, timeout_pulse, timeout_id
    );
    modport slave (
        input  request, end_transaction, weight_cfg, cfg_load,
        output grant, grant_id, busy, timeout_pulse, timeout_id
    );
endinterface

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin bus arbiter with turnaround cycle and per-grant watchdog
module wrr_arbiter #(
    parameter int N_AGENTS    = 4,
    parameter int WEIGHT_W    = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic          clk,
    input logic          rst,
    wrr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_AGENTS);
    localparam int WDW = $clog2(TIMEOUT_CYC);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2;
    logic [1:0]          state;
    logic [IDW-1:0]      last_served, win;
    logic [WEIGHT_W-1:0] weight [N_AGENTS];
    logic [WEIGHT_W-1:0] burst_left;
    logic [WDW-1:0]      wdog;
    logic                ended, expired, regrant;
    // farthest candidate visited first so the nearest requester after last_served wins
    always_comb begin
        win = last_served;
        for (int k = N_AGENTS; k >= 1; k--)
            if (bus.request[IDW'((int'(last_served) + k) % N_AGENTS)])
                win = IDW'((int'(last_served) + k) % N_AGENTS);
    end
    assign ended   = state == GRANT && bus.end_transaction[bus.grant_id];
    assign expired = state == GRANT && !ended && wdog == WDW'(TIMEOUT_CYC - 1);
    assign regrant = state == TURN && burst_left != '0 && bus.request[bus.grant_id];
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bus.grant         <= '0;
            bus.grant_id      <= '0;
            bus.busy          <= 1'b0;
            bus.timeout_pulse <= 1'b0;
            bus.timeout_id    <= '0;
            last_served       <= IDW'(N_AGENTS - 1);
            burst_left        <= '0;
            wdog              <= '0;
            for (int i = 0; i < N_AGENTS; i++) weight[i] <= WEIGHT_W'(1);
        end else begin
            bus.timeout_pulse <= 1'b0;
            if (bus.cfg_load)
                for (int i = 0; i < N_AGENTS; i++) weight[i] <= bus.weight_cfg[i*WEIGHT_W +: WEIGHT_W];
            if (state == GRANT) begin
                wdog <= wdog + 1'b1;
                if (ended || expired) begin
                    state     <= TURN;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                end
                if (expired) begin
                    bus.timeout_pulse <= 1'b1;
                    bus.timeout_id    <= bus.grant_id;
                    burst_left        <= '0;
                end
            end else if (regrant) begin
                state      <= GRANT;
                bus.grant  <= N_AGENTS'(1) << bus.grant_id;
                bus.busy   <= 1'b1;
                burst_left <= burst_left - 1'b1;
                wdog       <= '0;
            end else if (|bus.request) begin
                state        <= GRANT;
                bus.grant    <= N_AGENTS'(1) << win;
                bus.grant_id <= win;
                bus.busy     <= 1'b1;
                last_served  <= win;
                burst_left   <= weight[win] == '0 ? '0 : weight[win] - 1'b1;
                wdog         <= '0;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule
